// File: rtl/md_sequencer.sv
// rtl/md_sequencer.sv - iterative multiply/divide unit with HI/LO registers
// One radix-2 step per cycle (shift-add multiply, restoring divide) on magnitudes, sign fixed at the end.
module md_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      md_control,
  input  logic            rd_req,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  output logic            busy,
  output logic            stall,
  output logic [XLEN-1:0] rd_data,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            done
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   b_reg;
  logic              is_div;
  logic              neg_q;
  logic              neg_r;
  logic              div0;

  logic              is_move;
  logic              is_arith;
  logic              sgn;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   a_abs;
  logic [XLEN-1:0]   b_abs;

  assign is_move  = start & md_control[2];
  assign is_arith = start & ~md_control[2];
  assign sgn      = ~md_control[0];
  assign a_neg    = sgn & opa[XLEN-1];
  assign b_neg    = sgn & opb[XLEN-1];
  assign a_abs    = a_neg ? -opa : opa;
  assign b_abs    = b_neg ? -opb : opb;

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_step;
  logic [XLEN:0]     rem_shift;
  logic [XLEN:0]     div_diff;
  logic              div_ge;
  logic [XLEN-1:0]   rem_next;
  logic [2*XLEN-1:0] div_step;

  assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_reg} : '0);
  assign mul_step  = {mul_sum, acc[XLEN-1:1]};
  assign rem_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign div_diff  = rem_shift - {1'b0, b_reg};
  assign div_ge    = rem_shift >= {1'b0, b_reg};
  assign rem_next  = div_ge ? div_diff[XLEN-1:0] : rem_shift[XLEN-1:0];
  assign div_step  = {rem_next, acc[XLEN-2:0], div_ge};

  // Divide by zero yields quotient all-ones naturally; the remainder fix restores the original opa.
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;

  assign prod_fix = neg_q ? -acc : acc;
  assign quo_fix  = (neg_q & ~div0) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem_fix  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (is_arith) state_nxt = CALC;
      CALC:    if (cnt == CW'(XLEN - 1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      b_reg  <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (is_move) begin
            if (md_control[0]) lo <= opa;
            else               hi <= opa;
          end else if (is_arith) begin
            is_div <= md_control[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            div0   <= (opb == '0);
            b_reg  <= b_abs;
            acc    <= {{XLEN{1'b0}}, a_abs};
            cnt    <= '0;
          end
        end
        CALC: begin
          acc <= is_div ? div_step : mul_step;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*XLEN-1:XLEN];
            lo <= prod_fix[XLEN-1:0];
          end
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy    = (state != IDLE);
  assign stall   = (start | rd_req) & busy;
  assign rd_data = md_control[0] ? lo : hi;

endmodule

// File: doc/md_sequencer.md
# md_sequencer

Multi-cycle multiply/divide unit with its sequencer and the architectural HI/LO registers. It sits in EX beside the ALU. It accepts one mult/multu/div/divu/mthi/mtlo per issue, and serves mfhi/mflo reads. It raises `stall` back to the hazard logic while an operation is in flight. The unit is driven by the decoder's `updatemd`, `md_signal` and `md_control` outputs, carried down the pipeline to EX.

## Interface
- `XLEN`, default 32: operand/HI/LO width. Iteration count equals `XLEN`.
- `clk` in 1: clock, all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: EX-stage `updatemd`, qualified by EX valid. Level signal, sampled every edge.
- `md_control` in 3: operation code.
  - `000` mult, `001` multu, `010` div, `011` divu.
  - `100` mthi, `101` mtlo, `110` mfhi, `111` mflo.
- `rd_req` in 1: EX-stage `md_signal` (mfhi/mflo present).
- `opa` in XLEN: rs value, forwarded. Multiplicand, dividend, or mthi/mtlo source.
- `opb` in XLEN: rt value, forwarded. Multiplier or divisor.
- `busy` out 1: mult/div in flight.
- `stall` out 1: combinational, `(start | rd_req) & busy`. Holds EX and earlier stages.
- `rd_data` out XLEN: combinational. `md_control[0] ? lo : hi`.
- `hi`, `lo` out XLEN: architectural registers.
- `done` out 1: one-cycle pulse when a mult/div result is written.

## Operation
- States are IDLE, CALC, FIX. Iteration counter `cnt` is log2(XLEN)+1 bits.
- Reset (async): state=IDLE, hi=lo=0, busy=0, done=0, cnt=0, internal accumulators=0.
- IDLE, `start` with code `1x0`/`1x1` move (mthi/mtlo):
  - At the edge, hi (mthi) or lo (mtlo) is loaded with `opa`.
  - State stays IDLE; `done` is not pulsed.
- IDLE, `start` with mult/div:
  - Latch the opcode.
  - Latch |opa| and |opb| for signed ops, raw values for unsigned ops.
  - Latch the sign-fix flags:
    - Product sign = sign(opa) ^ sign(opb).
    - Quotient sign = sign(opa) ^ sign(opb).
    - Remainder sign = sign(opa).
  - Latch the divide-by-zero flag (`opb==0`).
  - cnt=0, state goes to CALC, busy=1.
- CALC, one radix-2 step per cycle, cnt increments. After cnt reaches XLEN-1, go to FIX.
  - Multiply: shift-add over a 2·XLEN accumulator.
  - Divide: restoring, one quotient bit per cycle, MSB first.
- FIX (1 cycle): apply two's-complement negation per the latched flags, then write {hi,lo}.
  - Multiply: hi=product[2XLEN-1:XLEN], lo=product[XLEN-1:0].
  - Divide: lo=quotient, hi=remainder.
  - Next edge: state=IDLE, busy=0, done=1 for exactly one cycle.
- Divide by zero: lo=all ones, hi=original `opa`. No sign fix is applied. No exception.
- Signed overflow (-2^(XLEN-1) / -1): lo=0x80000000, hi=0, from natural wrap. No exception.
- `start` while busy: ignored (stall holds the instruction). It is accepted on the first IDLE edge.
- `rd_req` while busy (including the FIX cycle): stall=1, `rd_data` is don't-care.
- `rd_req` in IDLE: no stall; `rd_data` reflects the current hi/lo.
- `start` and `rd_req` are mutually exclusive by decode. If both are high, start wins and rd_data is don't-care.
- `md_control`, `opa` and `opb` are only sampled on the accepting edge. Later changes during CALC have no effect.

## Timing
- Accept edge E0. CALC occupies cycles 1..XLEN. FIX is cycle XLEN+1.
- hi/lo are updated at edge E(XLEN+1).
- busy is high for exactly XLEN+1 cycles (33 at default).
- done is high in the cycle after E(XLEN+1), when busy is already 0.
- Back-to-back: the next mult/div can be accepted at edge E(XLEN+2), i.e. the edge ending the done cycle.
- mfhi immediately after mult: stalls 33 cycles, then reads the new hi in the done cycle.
- mthi/mtlo: value is visible on hi/lo and rd_data the cycle after the edge.
- Reset asserted mid-CALC: immediate return to IDLE, hi=lo=0, busy=0, no done pulse. Operation is lost.

## Test plan
- mult, opa=0xFFFFFFFD (-3), opb=5:
  - busy is high 33 cycles.
  - hi=0xFFFFFFFF, lo=0xFFFFFFF1.
  - done pulses once, in the cycle after busy falls.
- multu, opa=opb=0xFFFFFFFF: hi=0xFFFFFFFE, lo=0x00000001.
- div, opa=0xFFFFFFF9 (-7), opb=2: lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu, opa=0x12345678, opb=0: lo=0xFFFFFFFF, hi=0x12345678.
- div, opa=0x80000000, opb=0xFFFFFFFF: lo=0x80000000, hi=0.
- mult, then mflo asserted the next cycle:
  - stall is high until busy falls.
  - rd_data=correct lo in the done cycle.
- Reset mid-CALC (cycle 10), then mthi 0xA5A5A5A5, then mfhi:
  - After reset, hi=lo=0 and busy=0.
  - After mthi, rd_data=0xA5A5A5A5 with no stall.
